axi4_lite_mtimer: RTL and testbench

AXI4-Lite subordinate implementing the RISC-V machine timer (64-bit `mtime`, 64-bit `mtimecmp`) and the machine timer interrupt. It occupies one 16-byte downstream port of the AXI4-Lite crossbar, so its decode width is 4 address bits. It consumes the crossbar's per-subordinate channel signals and produces their ready, valid and response returns.

---
 rtl/mtimer_pkg.sv | 43 ++++
 rtl/axi4_lite.sv | 51 +++++
 rtl/mtimer_core.sv | 98 +++++++++
 rtl/axi4_lite_mtimer.sv | 170 +++++++++++++++++
 tb/tb_axi4_lite_mtimer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtimer_pkg.sv
// mtimer_pkg: shared definitions for the AXI4-Lite RISC-V machine timer.
//   - Register offsets within the 16-byte window (addr[3:0])
//   - AXI response codes
//   - Write / read handshake FSM state types
//   - Byte-strobe merge helper
// Optional feature macro used elsewhere: MTIMER_PRESCALER_EN.
`timescale 1ns/1ps
package mtimer_pkg;

  localparam logic [3:0] MTIME_LO    = 4'h0;
  localparam logic [3:0] MTIME_HI    = 4'h4;
  localparam logic [3:0] MTIMECMP_LO = 4'h8;
  localparam logic [3:0] MTIMECMP_HI = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  // Replace only the bytes of old_val whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_lite.sv
// axi4_lite: AXI4-Lite channel bundle (AW, W, B, AR, R) with clock and
// active-low reset carried in the interface.
//   aclk, areset_n : clock and asynchronous active-low reset (interface ports)
//   subordinate    : modport seen by a slave
//   manager        : modport seen by a master
`timescale 1ns/1ps
interface axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic aclk,
  input logic areset_n
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport subordinate (
    input  aclk, areset_n,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport manager (
    input  aclk, areset_n,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

endinterface

// File: rtl/mtimer_core.sv
// mtimer_core: 64-bit mtime / mtimecmp registers, optional prescaler,
// compare and registered machine timer interrupt.
//   clk, rst_n   : clock, asynchronous active-low reset
//   we           : write strobe (only asserted for aligned accesses)
//   waddr        : register offset, wdata / wstrb : data and byte strobes
//   raddr, rdata : combinational read port (0 for unmapped/misaligned)
//   irq          : registered (mtime >= mtimecmp)
// Macro MTIMER_PRESCALER_EN: when defined, mtime advances once every PRESCALE
// clocks; otherwise it advances every clock and PRESCALE is ignored.
`timescale 1ns/1ps
module mtimer_core
  import mtimer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  raddr,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        mtime_wr;

  assign mtime_wr = we && ((waddr == MTIME_LO) || (waddr == MTIME_HI));

`ifdef MTIMER_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc_q, presc_d;

  // Tick on the wrap edge; a write to mtime restarts the phase.
  always_comb begin
    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    if (mtime_wr) presc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE > 0);
  assign tick = 1'b1;
`endif

  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    // A write to one mtime half replaces the increment for the whole
    // register: the other half holds, so no carry crosses halves.
    if (we) begin
      case (waddr)
        MTIME_LO:    mtime_d = {mtime_q[63:32], strb_merge(mtime_q[31:0], wdata, wstrb)};
        MTIME_HI:    mtime_d = {strb_merge(mtime_q[63:32], wdata, wstrb), mtime_q[31:0]};
        MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], strb_merge(mtimecmp_q[31:0], wdata, wstrb)};
        MTIMECMP_HI: mtimecmp_d = {strb_merge(mtimecmp_q[63:32], wdata, wstrb), mtimecmp_q[31:0]};
        default: ;
      endcase
    end
    irq_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      MTIME_LO:    rdata = mtime_q[31:0];
      MTIME_HI:    rdata = mtime_q[63:32];
      MTIMECMP_LO: rdata = mtimecmp_q[31:0];
      MTIMECMP_HI: rdata = mtimecmp_q[63:32];
      default:     rdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: rtl/axi4_lite_mtimer.sv
// axi4_lite_mtimer: AXI4-Lite subordinate exposing the RISC-V machine timer.
//   axi : axi4_lite.subordinate (aclk, areset_n, AW/W/B/AR/R channels);
//         only addr[3:0] is decoded
//   irq : machine timer interrupt, level, registered
// Holds independent write and read handshake FSMs around mtimer_core.
// Macro MTIMER_PRESCALER_EN enables the PRESCALE tick divider in the core.
`timescale 1ns/1ps
module axi4_lite_mtimer
  import mtimer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PRESCALE   = 1
) (
  axi4_lite.subordinate axi,
  output logic          irq
);

  logic clk;
  logic rst_n;
  assign clk   = axi.aclk;
  assign rst_n = axi.areset_n;

  // Upper address bits are decoded by the crossbar.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{axi.awaddr[ADDR_WIDTH-1:4], axi.araddr[ADDR_WIDTH-1:4]};

  // ---------------- write path ----------------
  wr_state_t         wr_state_q, wr_state_d;
  logic [3:0]        awaddr_q, awaddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              aw_hs, w_hs;
  logic              core_we;
  logic [3:0]        core_waddr;
  logic [WIDTH-1:0]  core_wdata;
  logic [3:0]        core_wstrb;

  assign axi.awready = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_D);
  assign axi.wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_A);
  assign axi.bvalid  = (wr_state_q == W_RESP);
  assign axi.bresp   = bresp_q;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  // The core sees whichever address/data is arriving this cycle, or the
  // copy latched by an earlier handshake, so the update lands on the
  // same edge that enters W_RESP.
  assign core_waddr = aw_hs ? axi.awaddr[3:0] : awaddr_q;
  assign core_wdata = w_hs ? axi.wdata : wdata_q;
  assign core_wstrb = w_hs ? axi.wstrb : wstrb_q;

  always_comb begin
    logic go_resp;
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    core_we    = 1'b0;
    go_resp    = 1'b0;

    if (aw_hs) awaddr_d = axi.awaddr[3:0];
    if (w_hs) begin
      wdata_d = axi.wdata;
      wstrb_d = axi.wstrb;
    end

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) go_resp = 1'b1;
        else if (aw_hs)    wr_state_d = W_HAVE_A;
        else if (w_hs)     wr_state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  go_resp = 1'b1;
      W_HAVE_D: if (aw_hs) go_resp = 1'b1;
      W_RESP:   if (axi.bready) wr_state_d = W_IDLE;
      default:  wr_state_d = W_IDLE;
    endcase

    if (go_resp) begin
      wr_state_d = W_RESP;
      if (core_waddr[1:0] == 2'b00) begin
        bresp_d = RESP_OKAY;
        core_we = 1'b1;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  // ---------------- read path ----------------
  rd_state_t        rd_state_q, rd_state_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [31:0]      core_rdata;

  assign axi.arready = (rd_state_q == R_IDLE);
  assign axi.rvalid  = (rd_state_q == R_RESP);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (axi.arvalid) begin
          rd_state_d = R_RESP;
          if (axi.araddr[1:0] == 2'b00) begin
            rdata_d = core_rdata;
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_RESP:  if (axi.rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // ---------------- timer core ----------------
  mtimer_core #(
    .PRESCALE (PRESCALE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .wstrb (core_wstrb),
    .raddr (axi.araddr[3:0]),
    .rdata (core_rdata),
    .irq   (irq)
  );

endmodule

// File: tb/tb_axi4_lite_mtimer.sv
`timescale 1ns/1ps
module tb_axi4_lite_mtimer;

`ifdef MTIMER_PRESCALER_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;

  always #5 clk = ~clk;

  axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_if (.aclk(clk), .areset_n(rst_n));

  axi4_lite_mtimer #(.WIDTH(32), .ADDR_WIDTH(32), .PRESCALE(P)) dut (
    .axi (axi_if),
    .irq (irq)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  longint cyc      = 0;   // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: mtime is a linear function of elapsed edges since the
  // last reset/write ("base"); the previous segment is kept for lookbacks.
  logic [63:0] base_val, pbase_val, cmp_cur, cmp_prev;
  longint      base_cyc, pbase_cyc, cmp_edge;

  function automatic logic [63:0] mtime_at(longint c);
    if (c >= base_cyc) return base_val + 64'((c - base_cyc) / P);
    return pbase_val + 64'((c - pbase_cyc) / P);
  endfunction

  function automatic logic [63:0] cmp_at(longint c);
    return (c >= cmp_edge) ? cmp_cur : cmp_prev;
  endfunction

  function automatic logic exp_irq(longint c);
    return mtime_at(c - 1) >= cmp_at(c - 1);
  endfunction

  function automatic logic [31:0] merge32(logic [31:0] o, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a, longint c);
    logic [63:0] t, m;
    t = mtime_at(c);
    m = cmp_at(c);
    if (a[1:0] != 2'b00) return 32'h0;
    case (a[3:2])
      2'd0: return t[31:0];
      2'd1: return t[63:32];
      2'd2: return m[31:0];
      default: return m[63:32];
    endcase
  endfunction

  task automatic apply_write(logic [31:0] a, logic [31:0] d, logic [3:0] s, longint e);
    logic [63:0] pre;
    if (a[1:0] != 2'b00) return;
    pre = mtime_at(e - 1);
    case (a[3:2])
      2'd0, 2'd1: begin
        pbase_val = base_val;
        pbase_cyc = base_cyc;
        base_val  = (a[3:2] == 2'd0) ? {pre[63:32], merge32(pre[31:0], d, s)}
                                     : {merge32(pre[63:32], d, s), pre[31:0]};
        base_cyc  = e;
      end
      2'd2: begin
        cmp_prev = cmp_cur;
        cmp_cur  = {cmp_cur[63:32], merge32(cmp_cur[31:0], d, s)};
        cmp_edge = e;
      end
      default: begin
        cmp_prev = cmp_cur;
        cmp_cur  = {merge32(cmp_cur[63:32], d, s), cmp_cur[31:0]};
        cmp_edge = e;
      end
    endcase
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    base_val  = 64'h0;
    pbase_val = 64'h0;
    base_cyc  = cyc;
    pbase_cyc = cyc;
    cmp_cur   = '1;
    cmp_prev  = '1;
    cmp_edge  = cyc;
    $display("reset released at edge %0d", cyc);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("irq_idle", irq, exp_irq(cyc));
    end
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d, logic [3:0] s,
                          int aw_dly, int w_dly, int b_dly);
    bit aw_done, w_done, aw_fire, w_fire;
    longint e;
    logic [1:0] er;
    aw_done = 0;
    w_done  = 0;
    @(negedge clk);
    axi_if.awaddr = a;
    axi_if.wdata  = d;
    axi_if.wstrb  = s;
    for (int k = 0; k < 64; k++) begin
      if (aw_done && w_done) break;
      axi_if.awvalid = !aw_done && (k >= aw_dly);
      axi_if.wvalid  = !w_done && (k >= w_dly);
      if (w_done && !aw_done) chk("wready_have_d", axi_if.wready, 1'b0);
      aw_fire = axi_if.awvalid && axi_if.awready;
      w_fire  = axi_if.wvalid && axi_if.wready;
      @(posedge clk);
      @(negedge clk);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
    end
    axi_if.awvalid = 1'b0;
    axi_if.wvalid  = 1'b0;
    chk("wr_handshake_bound", {aw_done, w_done}, 2'b11);
    e = cyc;
    apply_write(a, d, s, e);
    er = (a[1:0] != 2'b00) ? 2'b10 : 2'b00;
    chk("bvalid_latency", axi_if.bvalid, 1'b1);
    chk("bresp", axi_if.bresp, er);
    for (int k = 0; k < b_dly; k++) begin
      chk("irq_wr", irq, exp_irq(cyc));
      @(negedge clk);
      chk("bvalid_hold", axi_if.bvalid, 1'b1);
      chk("bresp_hold", axi_if.bresp, er);
      chk("awready_resp", axi_if.awready, 1'b0);
      chk("wready_resp", axi_if.wready, 1'b0);
    end
    axi_if.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_if.bready = 1'b0;
    chk("bvalid_drop", axi_if.bvalid, 1'b0);
    $display("write addr=0x%h data=0x%h strb=%b bresp=%0d edge=%0d", a, d, s, axi_if.bresp, e);
  endtask

  task automatic do_read(logic [31:0] a, int ar_dly, int r_dly);
    bit done, fire;
    longint e;
    logic [31:0] ed;
    logic [1:0]  er;
    done = 0;
    @(negedge clk);
    axi_if.araddr = a;
    for (int k = 0; k < 64; k++) begin
      if (done) break;
      axi_if.arvalid = (k >= ar_dly);
      fire = axi_if.arvalid && axi_if.arready;
      @(posedge clk);
      @(negedge clk);
      if (fire) done = 1;
    end
    axi_if.arvalid = 1'b0;
    chk("rd_handshake_bound", done, 1'b1);
    e  = cyc;
    ed = exp_rd(a, e - 1);
    er = (a[1:0] != 2'b00) ? 2'b10 : 2'b00;
    chk("rvalid_latency", axi_if.rvalid, 1'b1);
    chk("rdata", axi_if.rdata, ed);
    chk("rresp", axi_if.rresp, er);
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      chk("rdata_hold", axi_if.rdata, ed);
      chk("arready_resp", axi_if.arready, 1'b0);
    end
    axi_if.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_if.rready = 1'b0;
    chk("rvalid_drop", axi_if.rvalid, 1'b0);
    $display("read  addr=0x%h rdata=0x%h rresp=%0d edge=%0d", a, axi_if.rdata, er, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    axi_if.awaddr = '0; axi_if.awvalid = 1'b0;
    axi_if.wdata  = '0; axi_if.wstrb   = '0; axi_if.wvalid = 1'b0;
    axi_if.bready = 1'b0;
    axi_if.araddr = '0; axi_if.arvalid = 1'b0;
    axi_if.rready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", axi_if.awready, 1'b1);
    chk("rst_wready",  axi_if.wready,  1'b1);
    chk("rst_arready", axi_if.arready, 1'b1);
    chk("rst_bvalid",  axi_if.bvalid,  1'b0);
    chk("rst_rvalid",  axi_if.rvalid,  1'b0);
    chk("rst_bresp",   axi_if.bresp,   2'b00);
    chk("rst_rresp",   axi_if.rresp,   2'b00);
    chk("rst_rdata",   axi_if.rdata,   32'h0);
    chk("rst_irq",     irq,            1'b0);
    release_reset();

    // Free-running count after reset
    idle(10);
    do_read(32'h0, 0, 0);
    do_read(32'h4, 1, 2);

    // Compare at 0x20: irq rises one cycle after mtime reaches it
    do_write(32'h8, 32'h0000_0020, 4'hF, 0, 0, 0);
    do_write(32'hC, 32'h0, 4'hF, 1, 0, 1);
    idle(24 * P);
    chk("irq_set", irq, 1'b1);

    // W three cycles ahead of AW, bready held low four cycles
    do_write(32'hC, 32'h1, 4'hF, 3, 0, 4);
    idle(3);
    chk("irq_clear", irq, 1'b0);

    // Partial-strobe write to mtime low half
    do_write(32'h0, 32'hFFFF_FFFF, 4'b0011, 0, 0, 0);
    idle(2);
    do_read(32'h0, 0, 0);

    // Misaligned accesses
    do_read(32'h6, 0, 1);
    do_write(32'hA, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_read(32'h8, 0, 0);
    do_read(32'hC, 0, 0);

    // 64-bit wrap
    do_write(32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_write(32'h0, 32'hFFFF_FFF0, 4'hF, 0, 1, 0);
    idle(24 * P);
    do_read(32'h4, 0, 0);
    do_read(32'h0, 0, 0);

    // Randomized mix
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: ra = 32'h4;
        2: ra = 32'h8;
        3: ra = 32'hC;
        default: ra = {28'h0, 4'($urandom_range(0, 15))};
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(ra, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3));
      idle($urandom_range(0, 4));
    end

    // Reset in the middle of a read response and a half-done write
    @(negedge clk);
    axi_if.araddr  = 32'h0;
    axi_if.arvalid = 1'b1;
    axi_if.awaddr  = 32'h8;
    axi_if.awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_if.arvalid = 1'b0;
    axi_if.awvalid = 1'b0;
    chk("mid_rvalid", axi_if.rvalid, 1'b1);
    chk("mid_awready_have_a", axi_if.awready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rvalid",  axi_if.rvalid,  1'b0);
    chk("abort_arready", axi_if.arready, 1'b1);
    chk("abort_awready", axi_if.awready, 1'b1);
    chk("abort_bvalid",  axi_if.bvalid,  1'b0);
    chk("abort_irq",     irq,            1'b0);
    release_reset();
    idle(5);
    do_read(32'h0, 0, 0);
    do_read(32'hC, 0, 0);
    do_write(32'h8, 32'h5, 4'hF, 0, 0, 0);
    do_write(32'hC, 32'h0, 4'hF, 0, 0, 0);
    idle(6 * P);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
